instr_decode_queue: RTL and testbench

- Parametrised decode buffer between instruction fetch and execute.
- Accepts raw 32-bit instructions with their PC over a valid/ready handshake.
- Decodes each instruction at enqueue time: fields, instruction type, fully sign-extended immediate, illegal flag.
- Holds DEPTH decoded entries in a FIFO and presents the head to the execute stage over a second valid/ready handshake. Supports pipeline flush on branch or trap.

---
 rtl/instr_decode_queue_pkg.sv | 50 +++++
 rtl/instr_predecode.sv | 126 ++++++++++++
 rtl/instr_decode_queue.sv | 81 ++++++++
 tb/tb_instr_decode_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_queue_pkg.sv
// Shared types for the instruction decode queue: opcodes, instruction types, decoded entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a. CSR fields exist only when RISCV_ZICSR_EN is defined.
package instr_decode_queue_pkg;

    typedef logic [31:0] raw_instr_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        TYPE_R  = 3'd0,
        TYPE_I  = 3'd1,
        TYPE_S  = 3'd2,
        TYPE_SB = 3'd3,
        TYPE_U  = 3'd4,
        TYPE_UJ = 3'd5
    } instr_type_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        instr_type_t itype;
        logic        illegal;
`ifdef RISCV_ZICSR_EN
        logic [11:0] csr_addr;
        logic        is_csr;
`endif
    } dec_entry_t;

    // Sign-extend a 12-bit immediate to 32 bits.
    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/instr_predecode.sv
// Combinational decoder: raw instruction -> decoded entry (fields, type, immediate, illegal).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; optional CSR decode under RISCV_ZICSR_EN.
module instr_predecode
    import instr_decode_queue_pkg::*;
(
    input  raw_instr_t i_instr,
    output dec_entry_t o_dec
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode = i_instr[6:0];
    assign w_rd     = i_instr[11:7];
    assign w_funct3 = i_instr[14:12];
    assign w_rs1    = i_instr[19:15];
    assign w_rs2    = i_instr[24:20];
    assign w_funct7 = i_instr[31:25];

    assign w_imm_i = sext12(i_instr[31:20]);
    assign w_imm_s = sext12({i_instr[31:25], i_instr[11:7]});
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Per-opcode field selection and legality; unused fields stay zero.
    always_comb begin
        o_dec        = '0;
        o_dec.opcode = w_opcode;
        case (w_opcode)
            OP_REG: begin
                o_dec.itype   = TYPE_R;
                o_dec.rd      = w_rd;
                o_dec.funct3  = w_funct3;
                o_dec.rs1     = w_rs1;
                o_dec.rs2     = w_rs2;
                o_dec.funct7  = w_funct7;
                o_dec.illegal = !((w_funct7 == 7'b0000000) ||
                                  (w_funct7 == 7'b0100000 &&
                                   (w_funct3 == 3'b000 || w_funct3 == 3'b101)));
            end
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                o_dec.itype  = TYPE_I;
                o_dec.rd     = w_rd;
                o_dec.funct3 = w_funct3;
                o_dec.rs1    = w_rs1;
                o_dec.imm    = w_imm_i;
                if (w_opcode == OP_LOAD)
                    o_dec.illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                    (w_funct3 == 3'b111);
                else if (w_opcode == OP_IMM)
                    // Shift-immediates carry funct7 in the upper immediate bits.
                    o_dec.illegal = (w_funct3 == 3'b001 && w_funct7 != 7'b0000000) ||
                                    (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 &&
                                     w_funct7 != 7'b0100000);
                else if (w_opcode == OP_JALR)
                    o_dec.illegal = (w_funct3 != 3'b000);
                else if (w_opcode == OP_SYSTEM) begin
`ifdef RISCV_ZICSR_EN
                    if (w_funct3 != 3'b000 && w_funct3 != 3'b100) begin
                        o_dec.is_csr   = 1'b1;
                        o_dec.csr_addr = i_instr[31:20];
                        // csrr*i variants take a 5-bit zero-extended immediate in rs1.
                        if (w_funct3[2])
                            o_dec.imm = {27'b0, i_instr[19:15]};
                    end else if (w_funct3 == 3'b000 &&
                                 (i_instr[31:7] == 25'b0 ||
                                  (i_instr[31:20] == 12'd1 && i_instr[19:7] == 13'b0))) begin
                        o_dec.illegal = 1'b0;
                    end else begin
                        o_dec.illegal = 1'b1;
                    end
`else
                    o_dec.illegal = 1'b1;
`endif
                end
            end
            OP_STORE, OP_BRANCH: begin
                o_dec.itype  = (w_opcode == OP_STORE) ? TYPE_S : TYPE_SB;
                o_dec.funct3 = w_funct3;
                o_dec.rs1    = w_rs1;
                o_dec.rs2    = w_rs2;
                if (w_opcode == OP_STORE) begin
                    o_dec.imm     = w_imm_s;
                    o_dec.illegal = (w_funct3 > 3'b010);
                end else begin
                    o_dec.imm     = w_imm_b;
                    o_dec.illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
                end
            end
            OP_LUI, OP_AUIPC: begin
                o_dec.itype = TYPE_U;
                o_dec.rd    = w_rd;
                o_dec.imm   = w_imm_u;
            end
            OP_JAL: begin
                o_dec.itype = TYPE_UJ;
                o_dec.rd    = w_rd;
                o_dec.imm   = w_imm_j;
            end
            default: begin
                // Unknown opcode: expose raw fields deterministically, flag illegal.
                o_dec.itype   = TYPE_R;
                o_dec.rd      = w_rd;
                o_dec.funct3  = w_funct3;
                o_dec.rs1     = w_rs1;
                o_dec.rs2     = w_rs2;
                o_dec.funct7  = w_funct7;
                o_dec.illegal = 1'b1;
            end
        endcase
        if (i_instr[1:0] != 2'b11)
            o_dec.illegal = 1'b1;
    end

endmodule

// File: rtl/instr_decode_queue.sv
// Decode queue between fetch and execute: decodes on enqueue, holds DEPTH entries in a FIFO.
// Latency: 1 cycle from accepted push to visibility at the head; no bypass.
// Backpressure: in_ready = not full from registered count only; flush empties at next edge. RISCV_ZICSR_EN enables CSR decode.
module instr_decode_queue
    import instr_decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output dec_entry_t               out_dec,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    dec_entry_t        r_mem_dec [DEPTH];
    logic [PC_W-1:0]   r_mem_pc  [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    dec_entry_t        w_dec;
    logic              w_push;
    logic              w_pop;

    instr_predecode u_predecode (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    assign in_ready  = (r_count != CNT_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;
    // Gate the head with out_valid so an empty queue always presents zeros.
    assign out_dec   = out_valid ? r_mem_dec[r_rd_ptr] : '0;
    assign out_pc    = out_valid ? r_mem_pc[r_rd_ptr]  : '0;

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: decoded fields and PC written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem_dec[r_wr_ptr] <= w_dec;
            r_mem_pc[r_wr_ptr]  <= in_pc;
        end
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: decode fields, FIFO order, full/empty, flush, illegal.
// Latency: checks 1-cycle push-to-head visibility.
// Backpressure: exercises full-plus-pop and flush-with-handshake cases.
module tb_instr_decode_queue;
    import instr_decode_queue_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    dec_entry_t       out_dec;
    logic [31:0]      out_pc;
    logic [2:0]       count;

    int checks = 0;
    int errors = 0;

    instr_decode_queue #(.DEPTH(4), .PC_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dec   (out_dec),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [31:0] ill_instr [12];
    logic        ill_exp   [12];
    int          rd_exp    [4];
    logic [31:0] pc_exp    [4];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_dec_zero", 64'(out_dec == '0), 64'd1);
        check("rst_out_pc", 64'(out_pc), 64'd0);

        // addi x1,x2,-1
        in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100;
        check("addi_no_bypass", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        check("addi_out_valid", 64'(out_valid), 64'd1);
        check("addi_count", 64'(count), 64'd1);
        check("addi_opcode", 64'(out_dec.opcode), 64'h13);
        check("addi_rd", 64'(out_dec.rd), 64'd1);
        check("addi_rs1", 64'(out_dec.rs1), 64'd2);
        check("addi_rs2_zero", 64'(out_dec.rs2), 64'd0);
        check("addi_imm", 64'(out_dec.imm), 64'hFFFFFFFF);
        check("addi_type", 64'(out_dec.itype), 64'(TYPE_I));
        check("addi_illegal", 64'(out_dec.illegal), 64'd0);
        check("addi_pc", 64'(out_pc), 64'h100);
        pop_one();
        check("addi_popped_count", 64'(count), 64'd0);

        // beq x0,x0,-4 then lui x5,0x12345
        in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 32'h200;
        step();
        in_instr = 32'h123452B7; in_pc = 32'h204;
        step();
        in_valid = 1'b0;
        check("beq_count", 64'(count), 64'd2);
        check("beq_imm", 64'(out_dec.imm), 64'hFFFFFFFC);
        check("beq_type", 64'(out_dec.itype), 64'(TYPE_SB));
        check("beq_rd_zero", 64'(out_dec.rd), 64'd0);
        check("beq_pc", 64'(out_pc), 64'h200);
        pop_one();
        check("lui_imm", 64'(out_dec.imm), 64'h12345000);
        check("lui_rd", 64'(out_dec.rd), 64'd5);
        check("lui_type", 64'(out_dec.itype), 64'(TYPE_U));
        check("lui_rs1_zero", 64'(out_dec.rs1), 64'd0);
        check("lui_pc", 64'(out_pc), 64'h204);
        pop_one();
        check("lui_popped_empty", 64'(out_valid), 64'd0);

        // Fill: 6 cycles of in_valid with out_ready low, only 4 accepted
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1;
            in_instr = 32'h13 | (32'(k) << 7);
            in_pc    = 32'h300 + 32'(4 * k);
            step();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head_rd", 64'(out_dec.rd), 64'd1);
        // Full plus pop: push held off this cycle, accepted the next
        in_instr = 32'h13 | (32'd7 << 7); in_pc = 32'h31C;
        pop_one();
        check("fullpop_count", 64'(count), 64'd3);
        check("fullpop_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("refill_count", 64'(count), 64'd4);
        rd_exp = '{2, 3, 4, 7};
        pc_exp = '{32'h308, 32'h30C, 32'h310, 32'h31C};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wrap_rd_%0d", k), 64'(out_dec.rd), 64'(rd_exp[k]));
            check($sformatf("wrap_pc_%0d", k), 64'(out_pc), 64'(pc_exp[k]));
            pop_one();
        end
        check("wrap_empty_count", 64'(count), 64'd0);

        // Flush with simultaneous push and pop at count=3
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            in_instr = 32'h13 | (32'(k) << 7);
            in_pc    = 32'h400 + 32'(4 * k);
            step();
        end
        check("preflush_count", 64'(count), 64'd3);
        flush = 1'b1; out_ready = 1'b1; in_instr = 32'h13 | (32'd9 << 7); in_pc = 32'h4F0;
        step();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_instr = 32'h13 | (32'd10 << 7); in_pc = 32'h500;
        step();
        in_valid = 1'b0;
        check("postflush_count", 64'(count), 64'd1);
        check("postflush_rd", 64'(out_dec.rd), 64'd10);
        check("postflush_pc", 64'(out_pc), 64'h500);
        pop_one();

        // Illegal encodings are still queued
        ill_instr = '{32'h0000007F, 32'h00000000, 32'h0000B003, 32'h40000033,
                      32'h02000033, 32'h00003023, 32'h0000A023, 32'h40005013,
                      32'h40001013, 32'h00001067, 32'h00002063, 32'h0000000F};
        ill_exp   = '{1'b1, 1'b1, 1'b1, 1'b0,
                      1'b1, 1'b1, 1'b0, 1'b0,
                      1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = ill_instr[k]; in_pc = 32'h600 + 32'(4 * k);
            step();
        end
        in_valid = 1'b0;
        check("illegal_queued_count", 64'(count), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("illegal_%0d", k), 64'(out_dec.illegal), 64'(ill_exp[k]));
            pop_one();
        end
        for (int k = 3; k < 12; k++) begin
            in_valid = 1'b1; in_instr = ill_instr[k]; in_pc = 32'h700;
            step();
            in_valid = 1'b0;
            check($sformatf("legality_%0d", k), 64'(out_dec.illegal), 64'(ill_exp[k]));
            pop_one();
        end

        // SYSTEM opcode: csrrw x0,mtvec,x5 and ecall
        in_valid = 1'b1; in_instr = 32'h30529073; in_pc = 32'h800;
        step();
        in_instr = 32'h00000073; in_pc = 32'h804;
        step();
        in_valid = 1'b0;
        check("csrrw_rs1", 64'(out_dec.rs1), 64'd5);
`ifdef RISCV_ZICSR_EN
        check("csrrw_illegal", 64'(out_dec.illegal), 64'd0);
        check("csrrw_is_csr", 64'(out_dec.is_csr), 64'd1);
        check("csrrw_addr", 64'(out_dec.csr_addr), 64'h305);
        pop_one();
        check("ecall_illegal", 64'(out_dec.illegal), 64'd0);
        check("ecall_is_csr", 64'(out_dec.is_csr), 64'd0);
`else
        check("csrrw_illegal", 64'(out_dec.illegal), 64'd1);
        pop_one();
        check("ecall_illegal", 64'(out_dec.illegal), 64'd1);
`endif
        pop_one();
        check("final_empty", 64'(out_valid), 64'd0);

        // Reset has priority over flush and clears a non-empty queue
        in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h900;
        step();
        in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        check("rst_again_count", 64'(count), 64'd0);
        check("rst_again_pc", 64'(out_pc), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
